calc_unit: RTL and testbench
============================

Name: calc_unit

Overview:
- Downstream consumer of the keypad input unit's signed operand.
- Takes the unit's 8-bit two's-complement value and its valid flag.
- Captures operand A, then operand B, on user "enter" button presses, computes A+B or A−B with signed-overflow detection, and holds the result for the display stage.
- Sits between the input unit and the seven-segment/LED output logic.

Parameters:
- W, 8, operand/result width in bits (two's complement).
- SYNC_STAGES, 2, synchronizer depth on the asynchronous button inputs (minimum 2).

Ports:
- CLOCK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_data  input  W  signed operand from the input unit, two's complement.
- in_valid  input  1  1 = in_data is within ±127 and may be accepted.
- load_btn  input  1  raw "enter" button, active-high, asynchronous.
- clr_btn  input  1  raw "clear" button, active-high, asynchronous.
- op_sub  input  1  0 = add, 1 = subtract; sampled only when B is captured.
- op_a  output  W  captured operand A.
- op_b  output  W  captured operand B.
- result  output  W  registered A op B, wrapped modulo 2^W.
- ovf  output  1  signed overflow of the held result.
- err  output  1  the last enter press was rejected because in_valid was 0.
- stage  output  2  current FSM state, for LED display.

Behaviour:
- RESET:
  - Synchronous: on any rising edge with RESET=1, all outputs go to 0 and stage goes to S_A.
  - Synchronizer flops are cleared, so no pulse follows reset release while a button is held.
  - RESET mid-operation abandons captured operands.
- Button conditioning:
  - Each button passes through a SYNC_STAGES-flop synchronizer followed by a rising-edge detector, producing a one-cycle pulse (load_p, clr_p).
  - A button sampled high at edge k produces a pulse during cycle k+SYNC_STAGES-1. Its action is registered at edge k+SYNC_STAGES (edge k+2 at default).
  - A held button yields exactly one pulse. Release followed by re-press yields another.
- Priority: RESET > clr_p > load_p.
  - clr_p in any state: op_a, op_b, result, ovf and err are cleared to 0; stage goes to S_A.
- FSM states: S_A=0, S_B=1, S_RES=2; encoding 3 is illegal and recovers to S_A on the next edge.
  - S_A, load_p with in_valid=1: op_a←in_data, err←0, go to S_B.
  - S_A, load_p with in_valid=0: err←1, stay in S_A; op_a is unchanged.
  - S_B, load_p with in_valid=1: op_b←in_data, err←0, and result/ovf are computed from op_a and in_data with the current op_sub. All are registered on the same edge; go to S_RES. Result latency is one clock after the pulse.
  - S_B, load_p with in_valid=0: err←1, stay in S_B.
  - S_RES, load_p: go to S_A; op_a, op_b, result, ovf and err are cleared; in_valid is ignored.
  - No load_p and no clr_p: hold everything.
- Arithmetic:
  - add: R = A + B.
  - sub: R = A + ~B + 1.
  - Both are truncated to W bits (wrap).
  - ovf = (A[W-1] == B'[W-1]) && (R[W-1] != A[W-1]), where B' is B for add and ~B+1 for sub. For sub, equivalently: A and B signs differ and R's sign differs from A.
  - Sub with B = −2^(W-1) must use the sign rule above, not B'.
- in_data and in_valid are sampled only on the capture edge. Changes at other times have no effect.

Decomposition:
- Shared package/header (calc_pkg): S_A, S_B, S_RES state constants; OP_ADD=0, OP_SUB=1; default W=8.
- One sub-module: btn_edge_sync (parameter SYNC_STAGES; ports CLOCK, RESET, btn_in, pulse_out). It is instantiated twice, for load and clr.
- FSM, capture registers and adder/overflow logic stay in calc_unit.

Test Plan:
- Reset release: hold load_btn=1 through RESET, then release RESET → no pulse. stage=0 and all outputs 0; the first action comes only after a 0→1 transition.
- Add with overflow: enter A=127 (0x7F), then B=1 (0x01), op_sub=0 → op_a=0x7F, op_b=0x01, result=0x80, ovf=1, stage=2. Result appears one clock after load_p.
- Subtract, no overflow: enter A=−127 (0x81), then B=1 (0x01), op_sub=1 → result=0x80 (−128), ovf=0. Then A=−127, B=127, op_sub=1 → result=0x02, ovf=1.
- Invalid rejection: in S_A press enter with in_valid=0, in_data=0x55 → err=1, stage=0, op_a=0. Re-press with in_valid=1, in_data=0x05 → op_a=0x05, err=0, stage=1.
- Held button: hold load_btn high for 50 cycles in S_A with in_valid=1 → exactly one transition to S_B; op_b is not captured.
- Clear priority: in S_B, assert load_btn and clr_btn on the same cycle → stage=0, op_a=0, err=0. Also check RESET asserted in S_RES clears result and ovf on the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator unit: FSM states, operation codes
// and the default operand width.
package calc_pkg;

    // Default operand/result width in bits (two's complement)
    localparam int CALC_W = 8;

    // Operation select values seen on op_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // FSM states; encoding 2'd3 is illegal and recovers to S_A
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } calc_state_e;

endpackage

// File: rtl/btn_edge_sync.sv
// Button conditioner: multi-flop synchronizer followed by a rising-edge
// detector that emits one registered pulse per press.
// SYNC_STAGES must be at least 2.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic btn_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] vld_r;
    logic                   pulse_r;

    // Synchronizer chain; vld_r tracks which stages hold real post-reset samples,
    // so a button held through reset is not mistaken for a fresh press
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            vld_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
            vld_r  <= {vld_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Registered edge pulse: look one stage ahead so the pulse is high exactly
    // while the last stage first shows a valid 1 after a valid 0
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= vld_r[SYNC_STAGES-2] & sync_r[SYNC_STAGES-2] &
                       vld_r[SYNC_STAGES-1] & ~sync_r[SYNC_STAGES-1];
        end
    end

    assign pulse_out = pulse_r;

endmodule

// File: rtl/calc_unit.sv
// Two-operand calculator: captures A then B on "enter" presses, computes
// A+B or A-B with signed-overflow detection and holds the result.
module calc_unit
    import calc_pkg::*;
#(
    parameter int W           = CALC_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         load_btn,
    input  logic         clr_btn,
    input  logic         op_sub,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         err,
    output logic [1:0]   stage
);

    logic         load_p_s;
    logic         clr_p_s;
    calc_state_e  state_r;
    calc_state_e  state_next_s;
    logic [W-1:0] op_a_r;
    logic [W-1:0] op_a_next_s;
    logic [W-1:0] op_b_r;
    logic [W-1:0] op_b_next_s;
    logic [W-1:0] result_r;
    logic [W-1:0] result_next_s;
    logic         ovf_r;
    logic         ovf_next_s;
    logic         err_r;
    logic         err_next_s;
    logic [W-1:0] b_eff_s;
    logic [W-1:0] sum_s;
    logic         ovf_calc_s;

    // Signed overflow from operand signs; subtraction uses the A/B sign rule
    // directly so B = -2^(W-1) is handled correctly
    function automatic logic signed_ovf(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic         sub,
                                        input logic [W-1:0] r);
        if (sub == OP_SUB) begin
            return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
    endfunction

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .btn_in    (load_btn),
        .pulse_out (load_p_s)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .btn_in    (clr_btn),
        .pulse_out (clr_p_s)
    );

    // Adder: A + B, or A + ~B + 1 for subtraction, wrapped to W bits
    always_comb begin
        b_eff_s    = (op_sub == OP_SUB) ? ~in_data : in_data;
        sum_s      = op_a_r + b_eff_s + {{(W-1){1'b0}}, op_sub};
        ovf_calc_s = signed_ovf(op_a_r, in_data, op_sub, sum_s);
    end

    // Next-state and next-register logic; priority is clear over enter
    always_comb begin
        state_next_s  = state_r;
        op_a_next_s   = op_a_r;
        op_b_next_s   = op_b_r;
        result_next_s = result_r;
        ovf_next_s    = ovf_r;
        err_next_s    = err_r;

        if (clr_p_s) begin
            state_next_s  = S_A;
            op_a_next_s   = {W{1'b0}};
            op_b_next_s   = {W{1'b0}};
            result_next_s = {W{1'b0}};
            ovf_next_s    = 1'b0;
            err_next_s    = 1'b0;
        end else begin
            case (state_r)
                S_A: begin
                    if (load_p_s && in_valid) begin
                        op_a_next_s  = in_data;
                        err_next_s   = 1'b0;
                        state_next_s = S_B;
                    end else if (load_p_s) begin
                        err_next_s   = 1'b1;
                    end else begin
                        state_next_s = S_A;
                    end
                end
                S_B: begin
                    if (load_p_s && in_valid) begin
                        op_b_next_s   = in_data;
                        result_next_s = sum_s;
                        ovf_next_s    = ovf_calc_s;
                        err_next_s    = 1'b0;
                        state_next_s  = S_RES;
                    end else if (load_p_s) begin
                        err_next_s    = 1'b1;
                    end else begin
                        state_next_s  = S_B;
                    end
                end
                S_RES: begin
                    if (load_p_s) begin
                        state_next_s  = S_A;
                        op_a_next_s   = {W{1'b0}};
                        op_b_next_s   = {W{1'b0}};
                        result_next_s = {W{1'b0}};
                        ovf_next_s    = 1'b0;
                        err_next_s    = 1'b0;
                    end else begin
                        state_next_s  = S_RES;
                    end
                end
                default: begin
                    state_next_s = S_A;
                end
            endcase
        end
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r  <= S_A;
            op_a_r   <= {W{1'b0}};
            op_b_r   <= {W{1'b0}};
            result_r <= {W{1'b0}};
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            op_a_r   <= op_a_next_s;
            op_b_r   <= op_b_next_s;
            result_r <= result_next_s;
            ovf_r    <= ovf_next_s;
            err_r    <= err_next_s;
        end
    end

    assign op_a   = op_a_r;
    assign op_b   = op_b_r;
    assign result = result_r;
    assign ovf    = ovf_r;
    assign err    = err_r;
    assign stage  = state_r;

endmodule

// File: tb/tb_calc_unit.sv
// Self-checking bench for calc_unit: table-driven arithmetic vectors,
// hand-written multi-cycle corner cases and a randomized run against an
// integer-arithmetic reference model.
module tb_calc_unit;

    logic       clock;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       load_btn;
    logic       clr_btn;
    logic       op_sub;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
    logic       ovf;
    logic       err;
    logic [1:0] stage;

    int checks;
    int failures;

    // Reference model: phase 0 = waiting for A, 1 = waiting for B, 2 = result held
    int         m_stage;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_r;
    logic       m_ovf;
    logic       m_err;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_r;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [8];

    calc_unit #(.W(8), .SYNC_STAGES(2)) dut (
        .CLOCK    (clock),
        .RESET    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .load_btn (load_btn),
        .clr_btn  (clr_btn),
        .op_sub   (op_sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .ovf      (ovf),
        .err      (err),
        .stage    (stage)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_stage = 0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_r = 8'h00;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_load(input logic [7:0] d, input logic v, input logic s);
        int ai;
        int bi;
        int ri;
        case (m_stage)
            0: begin
                if (v) begin
                    m_a = d;
                    m_err = 1'b0;
                    m_stage = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
            1: begin
                if (v) begin
                    ai = int'($signed(m_a));
                    bi = int'($signed(d));
                    ri = s ? (ai - bi) : (ai + bi);
                    m_b = d;
                    m_r = ri[7:0];
                    m_ovf = (ri > 127) || (ri < -128);
                    m_err = 1'b0;
                    m_stage = 2;
                end else begin
                    m_err = 1'b1;
                end
            end
            default: model_clear();
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".op_a"}, op_a, m_a);
        check({tag, ".op_b"}, op_b, m_b);
        check({tag, ".result"}, result, m_r);
        check({tag, ".ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
        check({tag, ".err"}, {7'd0, err}, {7'd0, m_err});
        check({tag, ".stage"}, {6'd0, stage}, 8'(m_stage));
    endtask

    task automatic press_load(input int hold);
        load_btn = 1'b1;
        tick(hold);
        load_btn = 1'b0;
        tick(3);
    endtask

    task automatic press_clr();
        clr_btn = 1'b1;
        tick(2);
        clr_btn = 1'b0;
        tick(3);
        model_clear();
    endtask

    // One enter press with given operand; inputs are scrambled afterwards
    task automatic enter(input logic [7:0] d, input logic v, input logic s);
        in_data = d;
        in_valid = v;
        op_sub = s;
        press_load(2);
        model_load(d, v, s);
        in_data = 8'($urandom);
        in_valid = 1'($urandom);
        op_sub = 1'($urandom);
    endtask

    initial begin
        int sel;
        int dv;
        logic [7:0] rd;
        logic rv;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_data = 8'h00;
        in_valid = 1'b0;
        load_btn = 1'b1;
        clr_btn = 1'b0;
        op_sub = 1'b0;
        model_clear();

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b1};
        vecs[1] = '{8'h81, 8'h01, 1'b1, 8'h80, 1'b0};
        vecs[2] = '{8'h81, 8'h7F, 1'b1, 8'h02, 1'b1};
        vecs[3] = '{8'h05, 8'hFB, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b1};
        vecs[5] = '{8'h81, 8'h81, 1'b0, 8'h02, 1'b1};
        vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0};
        vecs[7] = '{8'h7F, 8'h81, 1'b1, 8'hFE, 1'b1};

        // Reset with load button held: no pulse after release
        tick(3);
        check_all("reset");
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick(10);
        check_all("reset_release_held");
        load_btn = 1'b0;
        tick(3);
        enter(8'h11, 1'b1, 1'b0);
        check_all("first_press");
        press_clr();
        check_all("clear_after_first");

        // Table-driven arithmetic vectors
        for (int i = 0; i < 8; i++) begin
            enter(vecs[i].a, 1'b1, 1'b0);
            enter(vecs[i].b, 1'b1, vecs[i].sub);
            check($sformatf("vec%0d.op_a", i), op_a, vecs[i].a);
            check($sformatf("vec%0d.op_b", i), op_b, vecs[i].b);
            check($sformatf("vec%0d.result", i), result, vecs[i].exp_r);
            check($sformatf("vec%0d.ovf", i), {7'd0, ovf}, {7'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d.stage", i), {6'd0, stage}, 8'd2);
            enter(8'h33, 1'b1, 1'b0);
            check_all($sformatf("vec%0d_cleared", i));
        end

        // Result latency: registered on the edge after the pulse cycle
        enter(8'h7F, 1'b1, 1'b0);
        in_data = 8'h01;
        in_valid = 1'b1;
        op_sub = 1'b0;
        load_btn = 1'b1;
        tick(2);
        check("lat.stage_pulse_cycle", {6'd0, stage}, 8'd1);
        check("lat.result_pulse_cycle", result, 8'h00);
        tick(1);
        check("lat.stage_after", {6'd0, stage}, 8'd2);
        check("lat.result_after", result, 8'h80);
        check("lat.ovf_after", {7'd0, ovf}, 8'd1);
        load_btn = 1'b0;
        tick(3);
        model_load(8'h01, 1'b1, 1'b0);
        check_all("lat_final");

        // RESET in S_RES clears result and ovf on the next edge
        reset = 1'b1;
        tick(1);
        model_clear();
        check("rst_res.result", result, 8'h00);
        check("rst_res.ovf", {7'd0, ovf}, 8'd0);
        check_all("rst_res");
        reset = 1'b0;
        tick(3);

        // Invalid rejection, then acceptance
        enter(8'h55, 1'b0, 1'b0);
        check("inv.err", {7'd0, err}, 8'd1);
        check("inv.op_a", op_a, 8'h00);
        check_all("inv");
        enter(8'h05, 1'b1, 1'b0);
        check("inv_ok.op_a", op_a, 8'h05);
        check_all("inv_ok");

        // Held button: exactly one transition
        press_clr();
        in_data = 8'h22;
        in_valid = 1'b1;
        op_sub = 1'b0;
        press_load(50);
        model_load(8'h22, 1'b1, 1'b0);
        check("held.stage", {6'd0, stage}, 8'd1);
        check("held.op_b", op_b, 8'h00);
        check_all("held");

        // Clear wins over simultaneous enter in S_B
        in_data = 8'h44;
        in_valid = 1'b1;
        load_btn = 1'b1;
        clr_btn = 1'b1;
        tick(2);
        load_btn = 1'b0;
        clr_btn = 1'b0;
        tick(3);
        model_clear();
        check("clrprio.stage", {6'd0, stage}, 8'd0);
        check("clrprio.op_a", op_a, 8'h00);
        check_all("clrprio");

        // Randomized sequence against the reference model
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 10) begin
                press_clr();
            end else begin
                rv = ($urandom_range(0, 99) < 80);
                if (rv) begin
                    dv = int'($urandom_range(0, 254)) - 127;
                    rd = dv[7:0];
                end else begin
                    rd = 8'($urandom);
                end
                enter(rd, rv, 1'($urandom));
            end
            check_all($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
